// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer.
// Reads instruction words from program memory over a req/ack handshake and
// holds them in the instruction register. It presents the opcode to the
// downstream halt check and then either dispatches the instruction to the
// execution driver or stops the machine. It owns the program counter.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch watchdog that raises
// a sticky fault and halts when memory does not acknowledge within
// TIMEOUT_CYCLES fetch cycles. Without the macro, FETCH waits indefinitely
// and fault is constant 0.
module fetch_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int INSTR_WIDTH    = 16,
  parameter int OPCODE_SIZE    = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              run_en,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic                              mem_ack,
  input  logic [INSTR_WIDTH-1:0]            mem_rdata,
  output logic [OPCODE_SIZE-1:0]            opcode,
  output logic [INSTR_WIDTH-OPCODE_SIZE-1:0] operand,
  output logic                              instr_valid,
  output logic                              exec_busy,
  input  logic                              exec_done,
  input  logic                              pc_load,
  input  logic [ADDR_WIDTH-1:0]             pc_load_value,
  output logic [ADDR_WIDTH-1:0]             pc,
  output logic                              halted,
  output logic                              fault
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  state_t                   state_r;
  logic [ADDR_WIDTH-1:0]    pc_r;
  logic [INSTR_WIDTH-1:0]   ir_r;
  logic                     mem_req_r;
  logic                     instr_valid_r;
  logic                     exec_busy_r;
  logic                     halted_r;
  logic                     fault_r;
  logic                     timeout_hit_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] fetch_cnt_r;

  // Fetch watchdog: zero outside FETCH (so it starts at 0 on entry) and
  // counts each FETCH cycle that ends without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_r <= '0;
    end else if (state_r != ST_FETCH) begin
      fetch_cnt_r <= '0;
    end else if (!mem_ack) begin
      fetch_cnt_r <= fetch_cnt_r + CNT_WIDTH'(1);
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  // The current FETCH cycle is the last one allowed; an ack in it still wins
  // because the FSM tests mem_ack first.
  assign timeout_hit_s = (state_r == ST_FETCH) && (fetch_cnt_r == CNT_LAST);
`else
  // No watchdog in this build: the limit only shapes the enabled variant, so
  // this expression is constant false.
  assign timeout_hit_s = (TIMEOUT_CYCLES < 0);
`endif

  // Sequencer FSM: owns pc, IR and every handshake/status output as registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= '0;
      ir_r          <= '0;
      mem_req_r     <= 1'b0;
      instr_valid_r <= 1'b0;
      exec_busy_r   <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_FETCH;
            mem_req_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end

        ST_FETCH: begin
          // Request and address stay put until the ack arrives.
          if (mem_ack) begin
            ir_r          <= mem_rdata;
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b1;
            state_r       <= ST_DECODE;
          end else if (timeout_hit_s) begin
            mem_req_r <= 1'b0;
            fault_r   <= 1'b1;
            halted_r  <= 1'b1;
            state_r   <= ST_HALTED;
          end else begin
            mem_req_r <= 1'b1;
            state_r   <= ST_FETCH;
          end
        end

        ST_DECODE: begin
          // One-cycle decode window: the halt check's verdict is taken here.
          instr_valid_r <= 1'b0;
          if (run_en) begin
            pc_r        <= pc_r + ADDR_WIDTH'(1);
            exec_busy_r <= 1'b1;
            state_r     <= ST_EXECUTE;
          end else begin
            halted_r <= 1'b1;
            state_r  <= ST_HALTED;
          end
        end

        ST_EXECUTE: begin
          // A branch target is taken only together with exec_done.
          if (exec_done) begin
            exec_busy_r <= 1'b0;
            mem_req_r   <= 1'b1;
            state_r     <= ST_FETCH;
            if (pc_load) begin
              pc_r <= pc_load_value;
            end else begin
              pc_r <= pc_r;
            end
          end else begin
            exec_busy_r <= 1'b1;
            state_r     <= ST_EXECUTE;
          end
        end

        ST_HALTED: begin
          // Terminal: only reset leaves this state.
          halted_r  <= 1'b1;
          mem_req_r <= 1'b0;
          state_r   <= ST_HALTED;
        end

        default: begin
          // Unreachable encoding: fall back to a quiet idle machine.
          state_r       <= ST_IDLE;
          mem_req_r     <= 1'b0;
          instr_valid_r <= 1'b0;
          exec_busy_r   <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = pc_r;
  assign pc          = pc_r;
  assign opcode      = ir_r[INSTR_WIDTH-1 -: OPCODE_SIZE];
  assign operand     = ir_r[INSTR_WIDTH-OPCODE_SIZE-1:0];
  assign instr_valid = instr_valid_r;
  assign exec_busy   = exec_busy_r;
  assign halted      = halted_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer.
// Fetched words are pushed to a scoreboard when acked and popped when the
// DUT raises instr_valid; pc is tracked by a small independent model.
module tb_fetch_sequencer;
  localparam int AW = 8;
  localparam int IW = 16;
  localparam int OW = 8;
  localparam int TC = 15;

  logic          clk = 1'b0;
  logic          rst_n, start, run_en, mem_ack, exec_done, pc_load;
  logic [AW-1:0] pc_load_value;
  logic [IW-1:0] mem_rdata;
  logic          mem_req, instr_valid, exec_busy, halted, fault;
  logic [AW-1:0] mem_addr, pc;
  logic [OW-1:0] opcode;
  logic [IW-OW-1:0] operand;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] opd;
  } exp_t;

  exp_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] model_pc;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .OPCODE_SIZE(OW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_en(run_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .exec_busy(exec_busy), .exec_done(exec_done),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .pc(pc),
    .halted(halted), .fault(fault)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle: hold off the ack for 'delay' cycles, then ack.
  // Returns in the DECODE cycle after checking the decoded fields.
  task automatic fetch_word(input logic [IW-1:0] word, input int delay);
    exp_t e;
    check_val("fetch_req", {31'd0, mem_req}, 32'd1);
    check_val("fetch_addr", {24'd0, mem_addr}, {24'd0, model_pc});
    for (int i = 0; i < delay; i++) begin
      step();
      check_val("hold_req", {31'd0, mem_req}, 32'd1);
      check_val("hold_addr", {24'd0, mem_addr}, {24'd0, model_pc});
      check_val("hold_fault", {31'd0, fault}, 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = word;
    e.op      = word[15:8];
    e.opd     = word[7:0];
    exp_q.push_back(e);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'hDEAD;
    check_val("decode_valid", {31'd0, instr_valid}, 32'd1);
    check_val("decode_req", {31'd0, mem_req}, 32'd0);
    if (instr_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("opcode", {24'd0, opcode}, {24'd0, e.op});
      check_val("operand", {24'd0, operand}, {24'd0, e.opd});
    end
  endtask

  // From DECODE: run the instruction, stall 'stall' cycles with a stray
  // pc_load, then finish with an optional branch. Ends in the next FETCH.
  task automatic run_instr(input int stall, input logic do_load, input logic [AW-1:0] target);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    model_pc = model_pc + 8'd1;
    check_val("exec_busy", {31'd0, exec_busy}, 32'd1);
    check_val("exec_valid_low", {31'd0, instr_valid}, 32'd0);
    check_val("exec_pc", {24'd0, pc}, {24'd0, model_pc});
    for (int i = 0; i < stall; i++) begin
      pc_load       = 1'b1;
      pc_load_value = 8'h77;
      step();
      check_val("stall_busy", {31'd0, exec_busy}, 32'd1);
      check_val("stall_pc", {24'd0, pc}, {24'd0, model_pc});
    end
    exec_done     = 1'b1;
    pc_load       = do_load;
    pc_load_value = target;
    step();
    exec_done = 1'b0;
    pc_load   = 1'b0;
    if (do_load) model_pc = target;
    check_val("done_busy", {31'd0, exec_busy}, 32'd0);
    check_val("next_req", {31'd0, mem_req}, 32'd1);
    check_val("next_addr", {24'd0, mem_addr}, {24'd0, model_pc});
  endtask

  // From DECODE: halt check says stop.
  task automatic halt_instr();
    run_en = 1'b0;
    step();
    check_val("halted", {31'd0, halted}, 32'd1);
    check_val("halt_pc", {24'd0, pc}, {24'd0, model_pc});
    check_val("halt_req", {31'd0, mem_req}, 32'd0);
    check_val("halt_busy", {31'd0, exec_busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_pc = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; run_en = 1'b0; mem_ack = 1'b0;
    mem_rdata = 16'h0000; exec_done = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
    step();
    do_reset();
    check_val("rst_pc", {24'd0, pc}, 32'd0);
    check_val("rst_opcode", {24'd0, opcode}, 32'd0);
    check_val("rst_operand", {24'd0, operand}, 32'd0);
    check_val("rst_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_busy", {31'd0, exec_busy}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_fault", {31'd0, fault}, 32'd0);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    check_val("idle_req", {31'd0, mem_req}, 32'd0);
    check_val("idle_opcode", {24'd0, opcode}, 32'd0);
    check_val("idle_valid", {31'd0, instr_valid}, 32'd0);

    // Basic flow, stray pc_load during execute, branch, wrap.
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_word(16'h1234, 0);
    run_instr(2, 1'b0, 8'h00);
    fetch_word(16'hABCD, 3);
    run_instr(0, 1'b1, 8'h40);
    fetch_word(16'h5A5A, 1);
    run_instr(1, 1'b1, 8'hFF);
    fetch_word(16'h7788, 0);
    run_instr(0, 1'b0, 8'h00);

    // Reset while a fetch is pending, then a late ack.
    check_val("pre_rst_req", {31'd0, mem_req}, 32'd1);
    do_reset();
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    check_val("midrst_req", {31'd0, mem_req}, 32'd0);
    check_val("midrst_pc", {24'd0, pc}, 32'd0);
    check_val("midrst_opcode", {24'd0, opcode}, 32'd0);
    step();
    mem_ack = 1'b0;
    check_val("late_ack_req", {31'd0, mem_req}, 32'd0);
    check_val("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check_val("late_ack_operand", {24'd0, operand}, 32'd0);

    // Halt path, then start and acks are ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_word(16'h0100, 0);
    halt_instr();
    start = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("term_halted", {31'd0, halted}, 32'd1);
      check_val("term_req", {31'd0, mem_req}, 32'd0);
      check_val("term_opcode", {24'd0, opcode}, 32'h01);
    end
    start = 1'b0; mem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // No ack: fault and halt after TC fetch cycles.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < TC - 1; i++) step();
    check_val("to_pre_req", {31'd0, mem_req}, 32'd1);
    check_val("to_pre_fault", {31'd0, fault}, 32'd0);
    step();
    check_val("to_fault", {31'd0, fault}, 32'd1);
    check_val("to_halted", {31'd0, halted}, 32'd1);
    check_val("to_req", {31'd0, mem_req}, 32'd0);
    step();
    check_val("to_sticky", {31'd0, fault}, 32'd1);
    // Ack in the last allowed cycle wins.
    do_reset();
    check_val("to_rst_fault", {31'd0, fault}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_word(16'h4242, TC - 1);
    check_val("to_ack_fault", {31'd0, fault}, 32'd0);
    run_instr(0, 1'b0, 8'h00);
`else
    // No watchdog: a long stall keeps the request up with no fault.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_word(16'h4242, 20);
    check_val("wait_fault", {31'd0, fault}, 32'd0);
    run_instr(0, 1'b0, 8'h00);
`endif

    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer: reads instruction words from program memory over a req/ack handshake, holds them in an instruction register, and presents the opcode to the downstream halt check. It consumes that check's enable result to either dispatch the instruction to the execution driver or stop the machine. It sits directly upstream of the halt check and owns the program counter.

## Interface

Parameters:
- ADDR_WIDTH, 8, program counter / memory address width
- INSTR_WIDTH, 16, instruction word width
- OPCODE_SIZE, 8, opcode field width; the opcode is the top OPCODE_SIZE bits of the instruction word
- TIMEOUT_CYCLES, 15, fetch watchdog limit; used only when FETCH_TIMEOUT_EN is defined

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  leave IDLE and begin fetching
- run_en  in  1  halt-check result: 1 = execute, 0 = halt
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  read address, equal to pc
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  INSTR_WIDTH  instruction word
- opcode  out  OPCODE_SIZE  IR[INSTR_WIDTH-1 -: OPCODE_SIZE], registered
- operand  out  INSTR_WIDTH-OPCODE_SIZE  remaining IR bits
- instr_valid  out  1  high for exactly the DECODE cycle
- exec_busy  out  1  high while in EXECUTE
- exec_done  in  1  execution driver finished the current instruction
- pc_load  in  1  branch request; qualified by exec_done
- pc_load_value  in  ADDR_WIDTH  branch target
- pc  out  ADDR_WIDTH  program counter
- halted  out  1  sequencer is in HALTED
- fault  out  1  fetch timeout occurred; constant 0 without FETCH_TIMEOUT_EN

## Operation

- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- IDLE: outputs quiet. start=1 -> FETCH.
- FETCH: mem_req=1 and mem_addr=pc, both held stable until acknowledged. mem_ack=1 -> IR <= mem_rdata, then DECODE.
- DECODE: instr_valid=1, and run_en is sampled.
  - run_en=0 -> HALTED; pc is not incremented.
  - run_en=1 -> EXECUTE; pc <= pc+1, wrapping modulo 2^ADDR_WIDTH (0xFF -> 0x00).
- EXECUTE: exec_busy=1; wait for exec_done.
  - exec_done=1 -> FETCH.
  - exec_done=1 with pc_load=1 -> pc <= pc_load_value, which overrides the increment.
  - pc_load without exec_done is ignored.
- HALTED: halted=1. Terminal until rst_n=0; start is ignored.
- mem_ack outside FETCH is ignored, including a late ack after reset.
- Reset values: pc=0, IR=0 (opcode=0, operand=0), mem_req=0, instr_valid=0, exec_busy=0, halted=0, fault=0, state=IDLE.

## Timing

- start high at edge N -> mem_req high from cycle N+1.
- mem_ack at cycle M -> instr_valid high in cycle M+1.
- Minimum instruction period is 3 cycles (FETCH, DECODE, EXECUTE), reached when ack and exec_done arrive in their first cycle.
- opcode is stable from DECODE until the next accepted ack. run_en may be combinational from opcode; it is sampled only in DECODE.
- Reset asserted in any state (including FETCH with a pending request): all registers take their reset values at that edge; mem_req is low the next cycle.

## Configuration

- FETCH_TIMEOUT_EN defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: fault <= 1, mem_req drops, -> HALTED.
  - An ack in the same cycle the limit is reached wins; the fetch completes normally.
  - fault is sticky until reset.
- FETCH_TIMEOUT_EN undefined: no counter; FETCH waits indefinitely; fault tied 0.

## Test plan

- Reset then start; memory acks immediately with 0x1234 at address 0 -> opcode=0x12, operand=0x34, instr_valid for 1 cycle, pc=1 in EXECUTE; exec_done -> fetch at address 1.
- Word 0x0100 fetched, halt check drives run_en=0 -> halted=1 the cycle after DECODE, pc unchanged, no further mem_req, start ignored.
- exec_done with pc_load=1 and pc_load_value=0x40 -> next mem_addr=0x40. pc_load=1 with exec_done=0 -> no effect.
- pc=0xFF, non-halt instruction -> pc wraps to 0x00 and the next fetch is at address 0.
- Ack delayed 3 cycles -> mem_req and mem_addr held stable all 4 cycles. Reset mid-FETCH followed by a late ack -> state IDLE, IR=0.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> fault=1 and halted=1 after 15 FETCH cycles. Ack on the 15th cycle -> normal DECODE, fault=0.
